// File: rtl/uart_rx_ovs.sv
// Oversampled UART receiver: 2-flop sync, 3-sample majority vote, parity/stop checks, break hold-off.
// Latency: word and flags are registered one clk after the last stop bit's decision tick (2 clk sync ahead).
// Backpressure: single output register; a word completing while it is full and not being taken is dropped with an overrun pulse.
// Ports: clk/rst_n; rx serial in; m_data/m_valid/m_ready output handshake;
//        parity_err/frame_err/break_det flags qualified by m_valid; overrun pulse; busy = FSM not idle.
module uart_rx_ovs #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVS        = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  break_det,
    output logic                  overrun,
    output logic                  busy
);

    localparam int   DIV      = CLK_FREQ / (BAUD_RATE * OVS);
    localparam int   DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int   TICK_W   = $clog2(OVS);
    localparam int   BIT_W    = $clog2(DATA_WIDTH);
    localparam int   BIT_CLKS = DIV * OVS;
    localparam int   IDLE_W   = $clog2(BIT_CLKS);
    localparam logic PAR_REF  = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

    generate
        if (DATA_WIDTH < 5 || DATA_WIDTH > 9 || OVS < 8 || OVS > 32 || (OVS % 2) != 0 ||
            STOP_BITS < 1 || STOP_BITS > 2 || PARITY_EN < 0 || PARITY_EN > 1 ||
            PARITY_ODD < 0 || PARITY_ODD > 1 || DIV < 1) begin : g_param_err
            $error("uart_rx_ovs: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                  state, state_nxt;
    logic                    rx_meta, rx_s;
    logic [DIV_W-1:0]        div_cnt;
    logic [TICK_W-1:0]       tick_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic                    stop_cnt;
    logic [1:0]              smp;
    logic [DATA_WIDTH-1:0]   shreg;
    logic                    par_acc, fe_acc, zero_acc;
    logic                    brk_hold;
    logic [IDLE_W-1:0]       idle_cnt;

    logic tick_first, tick_last, decide, bit_end, vote, last_stop, frame_done;
    logic pe_final, fe_final, brk_final;

    // rx is asynchronous; sync flops idle high so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign tick_first = (div_cnt == '0);
    assign tick_last  = (div_cnt == DIV_W'(DIV - 1));
    // samples land on the first clk of ticks OVS/2-1 and OVS/2; the vote uses the live value at OVS/2+1
    assign decide     = tick_first && (tick_cnt == TICK_W'(OVS / 2 + 1));
    assign bit_end    = tick_last && (tick_cnt == TICK_W'(OVS - 1));
    assign vote       = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);
    assign last_stop  = (stop_cnt == 1'(STOP_BITS - 1));

    assign pe_final  = (PARITY_EN != 0) && (par_acc != PAR_REF);
    assign fe_final  = fe_acc | ~vote;
    // with two stop bits the first one has already been folded into zero_acc
    assign brk_final = zero_acc & (stop_cnt | ~vote);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        case (state)
            S_IDLE:   if (!brk_hold && !rx_s) state_nxt = S_START;
            S_START:  if (decide && vote) state_nxt = S_IDLE;
                      else if (bit_end)   state_nxt = S_DATA;
            S_DATA:   if (bit_end && bit_cnt == BIT_W'(DATA_WIDTH - 1))
                          state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (bit_end) state_nxt = S_STOP;
            // leave at the decision tick so a back-to-back start bit is not missed
            S_STOP:   if (decide && last_stop) begin
                          state_nxt  = S_IDLE;
                          frame_done = 1'b1;
                      end
            default:  state_nxt = S_IDLE;
        endcase
    end

    // tick generator, parked at zero while idle so START always begins at tick 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            tick_cnt <= '0;
        end else if (state == S_IDLE) begin
            div_cnt  <= '0;
            tick_cnt <= '0;
        end else if (tick_last) begin
            div_cnt  <= '0;
            tick_cnt <= (tick_cnt == TICK_W'(OVS - 1)) ? '0 : tick_cnt + TICK_W'(1);
        end else begin
            div_cnt  <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp      <= 2'b11;
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_acc  <= 1'b0;
            fe_acc   <= 1'b0;
            zero_acc <= 1'b1;
        end else if (state == S_IDLE) begin
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_acc  <= 1'b0;
            fe_acc   <= 1'b0;
            zero_acc <= 1'b1;
        end else begin
            if (tick_first && tick_cnt == TICK_W'(OVS / 2 - 1)) smp[0] <= rx_s;
            if (tick_first && tick_cnt == TICK_W'(OVS / 2))     smp[1] <= rx_s;
            case (state)
                S_DATA: begin
                    if (decide) begin
                        shreg    <= {vote, shreg[DATA_WIDTH-1:1]};
                        par_acc  <= par_acc ^ vote;
                        zero_acc <= zero_acc & ~vote;
                    end
                    if (bit_end)
                        bit_cnt <= (bit_cnt == BIT_W'(DATA_WIDTH - 1)) ? '0 : bit_cnt + BIT_W'(1);
                end
                S_PARITY: if (decide) begin
                    par_acc  <= par_acc ^ vote;
                    zero_acc <= zero_acc & ~vote;
                end
                S_STOP: begin
                    if (decide) begin
                        fe_acc <= fe_acc | ~vote;
                        if (!stop_cnt) zero_acc <= zero_acc & ~vote;
                    end
                    if (bit_end) stop_cnt <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // after a break the line must sit high for a whole bit before a new start bit is trusted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brk_hold <= 1'b0;
            idle_cnt <= '0;
        end else if (frame_done && brk_final) begin
            brk_hold <= 1'b1;
            idle_cnt <= '0;
        end else if (brk_hold && state == S_IDLE) begin
            if (!rx_s) begin
                idle_cnt <= '0;
            end else if (idle_cnt == IDLE_W'(BIT_CLKS - 1)) begin
                brk_hold <= 1'b0;
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data     <= '0;
            m_valid    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (frame_done && m_valid && !m_ready) begin
                overrun <= 1'b1;
            end else if (frame_done) begin
                m_data     <= shreg;
                m_valid    <= 1'b1;
                parity_err <= pe_final;
                frame_err  <= fe_final;
                break_det  <= brk_final;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench for uart_rx_ovs: three default instances, one with even parity, one with two stop bits.
// Independent scenarios run concurrently on separate instances; the reset-mid-frame case runs last.
// Expected words and flags are hand-computed constants.
module tb_uart_rx_ovs;

    localparam int BT = 864;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       bd;
    } word_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       rxl [5];
    logic       rdy [5];
    wire  [7:0] dat [5];
    wire        vld [5];
    wire        pe  [5];
    wire        fe  [5];
    wire        bd  [5];
    wire        ovr [5];
    wire        bsy [5];

    int total = 0;
    int bad   = 0;
    int ovr_cnt [5] = '{default: 0};
    word_t q0[$], q1[$], q2[$], q3[$], q4[$];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_def
            uart_rx_ovs u_dut (
                .clk(clk), .rst_n(rst_n), .rx(rxl[gi]),
                .m_data(dat[gi]), .m_valid(vld[gi]), .m_ready(rdy[gi]),
                .parity_err(pe[gi]), .frame_err(fe[gi]), .break_det(bd[gi]),
                .overrun(ovr[gi]), .busy(bsy[gi])
            );
        end
    endgenerate

    uart_rx_ovs #(.PARITY_EN(1), .PARITY_ODD(0)) u_par (
        .clk(clk), .rst_n(rst_n), .rx(rxl[3]),
        .m_data(dat[3]), .m_valid(vld[3]), .m_ready(rdy[3]),
        .parity_err(pe[3]), .frame_err(fe[3]), .break_det(bd[3]),
        .overrun(ovr[3]), .busy(bsy[3])
    );

    uart_rx_ovs #(.STOP_BITS(2)) u_stop2 (
        .clk(clk), .rst_n(rst_n), .rx(rxl[4]),
        .m_data(dat[4]), .m_valid(vld[4]), .m_ready(rdy[4]),
        .parity_err(pe[4]), .frame_err(fe[4]), .break_det(bd[4]),
        .overrun(ovr[4]), .busy(bsy[4])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input int sel, input word_t w);
        case (sel)
            0: q0.push_back(w);
            1: q1.push_back(w);
            2: q2.push_back(w);
            3: q3.push_back(w);
            default: q4.push_back(w);
        endcase
    endtask

    // returns all-ones when nothing was captured; no expected word has all three flags set
    task automatic pop_word(input int sel, output word_t w);
        w = '1;
        case (sel)
            0: if (q0.size() > 0) w = q0.pop_front();
            1: if (q1.size() > 0) w = q1.pop_front();
            2: if (q2.size() > 0) w = q2.pop_front();
            3: if (q3.size() > 0) w = q3.pop_front();
            default: if (q4.size() > 0) w = q4.pop_front();
        endcase
    endtask

    function automatic int qsize(input int sel);
        case (sel)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            3: return q3.size();
            default: return q4.size();
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (vld[i] && rdy[i]) push_word(i, {dat[i], pe[i], fe[i], bd[i]});
            if (ovr[i]) ovr_cnt[i]++;
        end
    end

    task automatic hold(input int sel, input logic v, input int n);
        rxl[sel] = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int sel, input logic [7:0] d, input int bt,
                        input logic par_en, input logic par, input int nstop, input logic s2);
        hold(sel, 1'b0, bt);
        for (int i = 0; i < 8; i++) hold(sel, d[i], bt);
        if (par_en) hold(sel, par, bt);
        hold(sel, 1'b1, bt);
        if (nstop == 2) hold(sel, s2, bt);
        rxl[sel] = 1'b1;
    endtask

    task automatic expect_word(input int sel, input string tag, input logic [7:0] d, input logic [2:0] f);
        word_t w;
        pop_word(sel, w);
        check({tag, "_data"}, w.d, d);
        check({tag, "_flags"}, {w.pe, w.fe, w.bd}, f);
    endtask

    // three back-to-back frames with the sender running at bit period bt
    task automatic frames3(input int sel, input int bt);
        send(sel, 8'h58, bt, 1'b0, 1'b0, 1, 1'b1);
        send(sel, 8'h37, bt, 1'b0, 1'b0, 1, 1'b1);
        send(sel, 8'h23, bt, 1'b0, 1'b0, 1, 1'b1);
        hold(sel, 1'b1, 2 * bt);
        check($sformatf("frames_cnt_bt%0d", bt), qsize(sel), 3);
        expect_word(sel, $sformatf("w58_bt%0d", bt), 8'h58, 3'b000);
        expect_word(sel, $sformatf("w37_bt%0d", bt), 8'h37, 3'b000);
        expect_word(sel, $sformatf("w23_bt%0d", bt), 8'h23, 3'b000);
    endtask

    initial begin
        for (int i = 0; i < 5; i++) begin
            rxl[i] = 1'b1;
            rdy[i] = 1'b1;
        end
        #3 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rst_valid%0d", i), vld[i], 0);
            check($sformatf("rst_busy%0d", i), bsy[i], 0);
            check($sformatf("rst_data%0d", i), dat[i], 0);
            check($sformatf("rst_outs%0d", i), {pe[i], fe[i], bd[i], ovr[i]}, 0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        fork
            begin : s_nominal_then_break
                frames3(0, BT);
                // long break, then a short low pulse inside the hold-off window
                hold(0, 1'b0, 12 * BT);
                check("brk_busy_end", bsy[0], 0);
                check("brk_cnt", qsize(0), 1);
                expect_word(0, "brk", 8'h00, 3'b011);
                hold(0, 1'b1, 500);
                rxl[0] = 1'b0;
                repeat (100) @(posedge clk);
                #1;
                check("brk_hold_busy", bsy[0], 0);
                hold(0, 1'b0, 100);
                hold(0, 1'b1, 1000);
                check("brk_hold_cnt", qsize(0), 0);
                send(0, 8'h3C, BT, 1'b0, 1'b0, 1, 1'b1);
                hold(0, 1'b1, BT);
                check("post_brk_cnt", qsize(0), 1);
                expect_word(0, "post_brk", 8'h3C, 3'b000);
            end
            begin : s_fast_then_overrun
                frames3(1, 890);
                rdy[1] = 1'b0;
                send(1, 8'h11, BT, 1'b0, 1'b0, 1, 1'b1);
                send(1, 8'h22, BT, 1'b0, 1'b0, 1, 1'b1);
                hold(1, 1'b1, BT);
                check("ovr_valid", vld[1], 1);
                check("ovr_data_kept", dat[1], 8'h11);
                check("ovr_pulses", ovr_cnt[1], 1);
                rdy[1] = 1'b1;
                @(posedge clk);
                #1 rdy[1] = 1'b0;
                @(negedge clk);
                check("ovr_valid_drop", vld[1], 0);
                check("ovr_accept_cnt", qsize(1), 1);
                expect_word(1, "ovr_acc", 8'h11, 3'b000);
            end
            begin : s_slow_then_glitch
                frames3(2, 838);
                rxl[2] = 1'b0;
                repeat (100) @(posedge clk);
                #1;
                check("glitch_busy_hi", bsy[2], 1);
                repeat (200) @(posedge clk);
                #1;
                hold(2, 1'b1, 900);
                check("glitch_busy_lo", bsy[2], 0);
                check("glitch_no_word", qsize(2), 0);
                send(2, 8'hA5, BT, 1'b0, 1'b0, 1, 1'b1);
                hold(2, 1'b1, BT);
                check("glitch_next_cnt", qsize(2), 1);
                expect_word(2, "glitch_next", 8'hA5, 3'b000);
            end
            begin : s_parity
                send(3, 8'h07, BT, 1'b1, 1'b1, 1, 1'b1);
                send(3, 8'h07, BT, 1'b1, 1'b0, 1, 1'b1);
                hold(3, 1'b1, BT);
                check("par_cnt", qsize(3), 2);
                expect_word(3, "par_ok", 8'h07, 3'b000);
                expect_word(3, "par_bad", 8'h07, 3'b100);
            end
            begin : s_two_stop
                send(4, 8'h5A, BT, 1'b0, 1'b0, 2, 1'b1);
                send(4, 8'h5A, BT, 1'b0, 1'b0, 2, 1'b0);
                hold(4, 1'b1, BT);
                check("stop2_cnt", qsize(4), 2);
                expect_word(4, "stop2_ok", 8'h5A, 3'b000);
                expect_word(4, "stop2_bad", 8'h5A, 3'b010);
            end
        join

        // reset in the middle of a frame with a word still pending
        rdy[0] = 1'b0;
        send(0, 8'h44, BT, 1'b0, 1'b0, 1, 1'b1);
        hold(0, 1'b1, BT);
        check("midrst_pending", vld[0], 1);
        rxl[0] = 1'b0;
        repeat (400) @(posedge clk);
        #1;
        check("midrst_busy_before", bsy[0], 1);
        rst_n = 1'b0;
        #2;
        check("midrst_valid", vld[0], 0);
        check("midrst_busy", bsy[0], 0);
        check("midrst_data", dat[0], 0);
        rxl[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        hold(0, 1'b1, 2 * BT);
        check("midrst_quiet", {vld[0], bsy[0]}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_ovs.md
Name: uart_rx_ovs

Overview:
- Next-generation parametrised UART receiver for the serial RX path; supersedes the fixed-format `rx` block.
- Adds oversampled majority-vote bit recovery, a 2-flop input synchronizer and false-start rejection.
- Supports optional even/odd parity and 1 or 2 stop bits.
- Delivers words over a valid/ready handshake with per-word error flags and overrun reporting.

Parameters:
- DATA_WIDTH, 8: data bits per frame, legal 5..9, LSB first.
- CLK_FREQ, 100_000_000: clk frequency in Hz.
- BAUD_RATE, 115200: line rate in bit/s.
- OVS, 16: oversampling ticks per bit, even, legal 8..32.
- PARITY_EN, 0: 1 = parity bit follows the data bits.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx  in  1  serial line, idle high, asynchronous to clk.
- m_data  out  DATA_WIDTH  received word.
- m_valid  out  1  m_data and the flags are valid.
- m_ready  in  1  consumer accepts the word when m_valid & m_ready.
- parity_err  out  1  word had a parity mismatch; qualified by m_valid.
- frame_err  out  1  a stop bit was sampled 0; qualified by m_valid.
- break_det  out  1  all data bits, the parity bit if present, and the first stop bit were 0; qualified by m_valid.
- overrun  out  1  one-clk pulse when a completed word was dropped.
- busy  out  1  high while the FSM is not in IDLE.

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low, ports clk and rst_n.
  - All outputs reset to 0, FSM goes to IDLE, synchronizer flops reset to 1.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD_RATE*OVS), integer truncation; for the defaults DIV = 54.
  - The tick counter runs only outside IDLE and restarts at 0 when START is entered.
  - One bit period = DIV*OVS clks.
- Input path: rx passes through two flops (rx_s). All decisions use rx_s, giving 2 clk of fixed latency.
- Sampling:
  - Within a bit, ticks are numbered 0..OVS-1.
  - Samples are taken at ticks OVS/2-1, OVS/2 and OVS/2+1; the bit value is the majority (2 of 3).
  - The bit is decided at tick OVS/2+1.
- FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: rx_s = 0 moves to START (level detect after sync).
  - START: if the voted bit is 1 (false start), return to IDLE with no output and no flags. Otherwise continue counting to the end of the bit, then enter DATA.
  - DATA: shift in DATA_WIDTH voted bits, LSB first. The bit counter wraps to PARITY when PARITY_EN = 1, else to STOP.
  - PARITY: compute XOR of the data bits and the parity bit. Error if the result is not PARITY_ODD.
  - STOP: one or two stop bits; each is voted.
    - frame_err is set if any stop bit votes 0.
    - The FSM returns to IDLE immediately after the last stop bit's decision tick. It does not wait for the bit end, so back-to-back frames are caught.
- Delivery:
  - One clk after the last stop decision, the word and its flags load into the output register and m_valid rises.
  - m_valid falls in the cycle after m_valid & m_ready is sampled high.
  - m_data and the flags are stable while m_valid = 1 and m_ready = 0.
- Overrun:
  - If a new word completes while m_valid = 1 and the same cycle's m_ready = 0: keep the old word, drop the new one, and pulse overrun for 1 clk.
  - If m_ready = 1 in that same cycle: the old word is consumed, the new word loads, m_valid stays high, and there is no overrun.
- Break: break_det = 1 implies frame_err = 1. The FSM waits in IDLE until rx_s has been 1 for one full bit period before it accepts a new start bit.
- Reset mid-frame: the frame is abandoned and m_valid is cleared.
- Parameter checks: out-of-range parameters must fail elaboration via a generate-time error.

Test Plan:
Default parameters, bit time 864 clk unless stated otherwise.
1. Frames 0x58, 0x37, 0x23 with m_ready held at 1 -> m_valid pulses 3 times with m_data 0x58, 0x37, 0x23; all error flags 0.
2. A 300-clk low glitch on an idle line -> no m_valid, busy returns to 0 and the next frame 0xA5 is received correctly.
3. PARITY_EN=1, PARITY_ODD=0:
   - 0x07 with parity bit 1 -> parity_err=0.
   - 0x07 with parity bit 0 -> parity_err=1, m_data=0x07.
4. STOP_BITS=2 with the second stop bit driven 0 on 0x5A -> frame_err=1, m_data=0x5A.
5. m_ready held at 0 for two frames 0x11 then 0x22 -> m_data stays 0x11, one overrun pulse. Then m_ready=1 accepts 0x11 and m_valid drops.
6. rx held at 0 for 12 bit times -> break_det=1 and frame_err=1 with m_data=0x00. No further word is produced until rx has been high for 864 clk. A following 0x3C is received correctly.
7. Repeat scenario 1 with the bit period at +3% and -3% of nominal -> identical results.
